// File: rtl/ball_physics.sv
// ball_physics: per-frame ball motion engine. Advances the ball on each
// frame tick, bounces it off the top/bottom walls and the paddle faces,
// detects goals, and freezes the ball for a hold period after each goal.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | ball parked at field centre, waiting for enable && serve
// MOVING  | ball advances one step per tick; walls, paddles, goals
// SCORED  | ball frozen at the goal line while the hold counter runs
module ball_physics #(
  parameter int FIELD_W     = 640,
  parameter int FIELD_H     = 480,
  parameter int BALL_HALF   = 4,
  parameter int PADDLE_HALF = 32,
  parameter int LEFT_FACE   = 24,
  parameter int RIGHT_FACE  = 615,
  parameter int SPEED       = 4,
  parameter int HOLD_TICKS  = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       tick,
  input  logic       serve,
  input  logic [9:0] left_paddle_loc,
  input  logic [9:0] right_paddle_loc,
  output logic [9:0] ball_loc_x,
  output logic [9:0] ball_loc_y,
  output logic       dir_x,
  output logic       dir_y,
  output logic       left_point,
  output logic       right_point,
  output logic       in_play
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MOVING = 2'd1,
    SCORED = 2'd2
  } state_t;

  // All position arithmetic is done in 11-bit signed so that x - SPEED and
  // similar never wrap before they are compared against the limits.
  localparam logic signed [10:0] HALF_S   = 11'(BALL_HALF);
  localparam logic signed [10:0] SPEED_S  = 11'(SPEED);
  localparam logic signed [10:0] Y_MAX_S  = 11'(FIELD_H - 1 - BALL_HALF);
  localparam logic signed [10:0] X_MAX_S  = 11'(FIELD_W - 1 - BALL_HALF);
  localparam logic signed [10:0] LFACE_S  = 11'(LEFT_FACE);
  localparam logic signed [10:0] RFACE_S  = 11'(RIGHT_FACE);
  localparam logic [10:0]        REACH    = 11'(PADDLE_HALF + BALL_HALF);
  localparam logic [9:0]         CENTRE_X = 10'(FIELD_W / 2);
  localparam logic [9:0]         CENTRE_Y = 10'(FIELD_H / 2);
  localparam logic [7:0]         HOLD_INIT = 8'(HOLD_TICKS);

  state_t     state;
  logic [7:0] hold_cnt;

  logic signed [10:0] xs;
  logic signed [10:0] ys;
  logic [9:0]         y_next;
  logic               dir_y_next;
  logic [9:0]         x_next;
  logic               dir_x_next;
  logic signed [10:0] paddle_s;
  logic signed [10:0] dy;
  logic [10:0]        abs_dy;
  logic               paddle_hit;
  logic               goal_right_edge;
  logic               goal_left_edge;

  // Next y (walls first), then next x using the new y for the paddle test.
  always_comb begin
    xs              = signed'({1'b0, ball_loc_x});
    ys              = signed'({1'b0, ball_loc_y});
    y_next          = ball_loc_y;
    dir_y_next      = dir_y;
    x_next          = ball_loc_x;
    dir_x_next      = dir_x;
    goal_right_edge = 1'b0;
    goal_left_edge  = 1'b0;

    if (dir_y) begin
      if (ys + SPEED_S > Y_MAX_S) begin
        y_next     = 10'(Y_MAX_S);
        dir_y_next = 1'b0;
      end else begin
        y_next = 10'(ys + SPEED_S);
      end
    end else begin
      if (ys < HALF_S + SPEED_S) begin
        y_next     = 10'(HALF_S);
        dir_y_next = 1'b1;
      end else begin
        y_next = 10'(ys - SPEED_S);
      end
    end

    // Paddle on the side the ball is heading towards.
    paddle_s   = dir_x ? signed'({1'b0, right_paddle_loc})
                       : signed'({1'b0, left_paddle_loc});
    dy         = signed'({1'b0, y_next}) - paddle_s;
    abs_dy     = (dy < 0) ? 11'(-dy) : 11'(dy);
    paddle_hit = (abs_dy <= REACH);

    if (dir_x) begin
      if (xs + SPEED_S > X_MAX_S) begin
        x_next          = 10'(X_MAX_S);
        goal_right_edge = 1'b1;
      end else if ((xs + HALF_S < RFACE_S) &&
                   (xs + SPEED_S + HALF_S >= RFACE_S) && paddle_hit) begin
        x_next     = 10'(RFACE_S - HALF_S);
        dir_x_next = 1'b0;
      end else begin
        x_next = 10'(xs + SPEED_S);
      end
    end else begin
      if (xs < HALF_S + SPEED_S) begin
        x_next         = 10'(HALF_S);
        goal_left_edge = 1'b1;
      end else if ((xs - HALF_S > LFACE_S) &&
                   (xs - SPEED_S - HALF_S <= LFACE_S) && paddle_hit) begin
        x_next     = 10'(LFACE_S + HALF_S);
        dir_x_next = 1'b1;
      end else begin
        x_next = 10'(xs - SPEED_S);
      end
    end
  end

  // Game state machine with registered ball outputs and point pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      hold_cnt    <= 8'd0;
      ball_loc_x  <= CENTRE_X;
      ball_loc_y  <= CENTRE_Y;
      dir_x       <= 1'b1;
      dir_y       <= 1'b1;
      left_point  <= 1'b0;
      right_point <= 1'b0;
      in_play     <= 1'b0;
    end else begin
      left_point  <= 1'b0;
      right_point <= 1'b0;
      if (!enable) begin
        state      <= IDLE;
        hold_cnt   <= 8'd0;
        ball_loc_x <= CENTRE_X;
        ball_loc_y <= CENTRE_Y;
        in_play    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            ball_loc_x <= CENTRE_X;
            ball_loc_y <= CENTRE_Y;
            // serve takes priority over a coincident tick: no motion yet
            if (serve) begin
              state   <= MOVING;
              in_play <= 1'b1;
            end
          end
          MOVING: begin
            if (tick) begin
              ball_loc_x <= x_next;
              ball_loc_y <= y_next;
              dir_x      <= dir_x_next;
              dir_y      <= dir_y_next;
              if (goal_right_edge || goal_left_edge) begin
                state       <= SCORED;
                in_play     <= 1'b0;
                hold_cnt    <= HOLD_INIT;
                left_point  <= goal_right_edge;
                right_point <= goal_left_edge;
              end
            end
          end
          SCORED: begin
            if (tick) begin
              if (hold_cnt <= 8'd1) begin
                // dir_x is untouched by a goal, so it already points at the
                // goal the ball left through, i.e. toward the conceding side.
                state      <= IDLE;
                hold_cnt   <= 8'd0;
                ball_loc_x <= CENTRE_X;
                ball_loc_y <= CENTRE_Y;
              end else begin
                hold_cnt <= hold_cnt - 8'd1;
              end
            end
          end
          default: begin
            state   <= IDLE;
            in_play <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ball_physics.sv
// tb_ball_physics: directed bench for ball_physics with hand-computed values.
module tb_ball_physics;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       tick = 1'b0;
  logic       serve = 1'b0;
  logic [9:0] left_paddle_loc = 10'd0;
  logic [9:0] right_paddle_loc = 10'd419;
  logic [9:0] ball_loc_x;
  logic [9:0] ball_loc_y;
  logic       dir_x;
  logic       dir_y;
  logic       left_point;
  logic       right_point;
  logic       in_play;

  int errors = 0;
  int checks = 0;

  ball_physics dut (
    .clk              (clk),
    .reset            (reset),
    .enable           (enable),
    .tick             (tick),
    .serve            (serve),
    .left_paddle_loc  (left_paddle_loc),
    .right_paddle_loc (right_paddle_loc),
    .ball_loc_x       (ball_loc_x),
    .ball_loc_y       (ball_loc_y),
    .dir_x            (dir_x),
    .dir_y            (dir_y),
    .left_point       (left_point),
    .right_point      (right_point),
    .in_play          (in_play)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      tick = 1'b1;
      cycle();
      tick = 1'b0;
    end
  endtask

  task automatic serve_pulse(input logic with_tick);
    serve = 1'b1;
    tick  = with_tick;
    cycle();
    serve = 1'b0;
    tick  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cycle(); cycle();
    reset = 1'b0;
    enable = 1'b1;
    serve_pulse(1'b0);
    tick_n(5);
    checks++; if (ball_loc_x !== 10'd340) begin errors++; $display("FAIL pre_reset_x: got %0d expected 340", ball_loc_x); end
    reset = 1'b1;
    cycle(); cycle();
    reset = 1'b0;
    checks++; if (ball_loc_x !== 10'd320) begin errors++; $display("FAIL reset_x: got %0d expected 320", ball_loc_x); end
    checks++; if (ball_loc_y !== 10'd240) begin errors++; $display("FAIL reset_y: got %0d expected 240", ball_loc_y); end
    checks++; if ({dir_x, dir_y} !== 2'b11) begin errors++; $display("FAIL reset_dir: got %b expected 11", {dir_x, dir_y}); end
    checks++; if ({in_play, left_point, right_point} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {in_play, left_point, right_point}); end
    tick_n(2);
    checks++; if ({ball_loc_x, ball_loc_y, in_play} !== {10'd320, 10'd240, 1'b0}) begin errors++; $display("FAIL reset_idle_tick: got x=%0d y=%0d in_play=%b expected 320 240 0", ball_loc_x, ball_loc_y, in_play); end
  endtask

  task automatic test_serve_step();
    serve_pulse(1'b1);
    checks++; if (in_play !== 1'b1) begin errors++; $display("FAIL serve_in_play: got %b expected 1", in_play); end
    checks++; if ({ball_loc_x, ball_loc_y} !== {10'd320, 10'd240}) begin errors++; $display("FAIL serve_no_move: got %0d,%0d expected 320,240", ball_loc_x, ball_loc_y); end
    tick_n(1);
    checks++; if ({ball_loc_x, ball_loc_y} !== {10'd324, 10'd244}) begin errors++; $display("FAIL first_step: got %0d,%0d expected 324,244", ball_loc_x, ball_loc_y); end
    repeat (10) cycle();
    checks++; if ({ball_loc_x, ball_loc_y, in_play} !== {10'd324, 10'd244, 1'b1}) begin errors++; $display("FAIL hold_no_tick: got %0d,%0d in_play=%b expected 324,244 1", ball_loc_x, ball_loc_y, in_play); end
  endtask

  task automatic test_bottom_bounce();
    tick_n(57);
    checks++; if ({ball_loc_x, ball_loc_y, dir_y} !== {10'd552, 10'd472, 1'b1}) begin errors++; $display("FAIL tick58: got x=%0d y=%0d dir_y=%b expected 552 472 1", ball_loc_x, ball_loc_y, dir_y); end
    tick_n(1);
    checks++; if ({ball_loc_x, ball_loc_y, dir_y} !== {10'd556, 10'd475, 1'b0}) begin errors++; $display("FAIL bottom_bounce: got x=%0d y=%0d dir_y=%b expected 556 475 0", ball_loc_x, ball_loc_y, dir_y); end
  endtask

  task automatic test_right_hit();
    tick_n(13);
    checks++; if ({ball_loc_x, ball_loc_y} !== {10'd608, 10'd423}) begin errors++; $display("FAIL tick72: got %0d,%0d expected 608,423", ball_loc_x, ball_loc_y); end
    tick_n(1);
    checks++; if ({ball_loc_x, ball_loc_y, dir_x} !== {10'd611, 10'd419, 1'b0}) begin errors++; $display("FAIL right_hit: got x=%0d y=%0d dir_x=%b expected 611 419 0", ball_loc_x, ball_loc_y, dir_x); end
    checks++; if ({left_point, right_point, in_play} !== 3'b001) begin errors++; $display("FAIL right_hit_flags: got %b expected 001", {left_point, right_point, in_play}); end
  endtask

  task automatic test_left_goal();
    tick_n(103);
    checks++; if ({ball_loc_x, ball_loc_y, dir_y} !== {10'd199, 10'd7, 1'b0}) begin errors++; $display("FAIL tick176: got x=%0d y=%0d dir_y=%b expected 199 7 0", ball_loc_x, ball_loc_y, dir_y); end
    tick_n(1);
    checks++; if ({ball_loc_x, ball_loc_y, dir_y} !== {10'd195, 10'd4, 1'b1}) begin errors++; $display("FAIL top_bounce: got x=%0d y=%0d dir_y=%b expected 195 4 1", ball_loc_x, ball_loc_y, dir_y); end
    tick_n(42);
    checks++; if ({ball_loc_x, ball_loc_y, dir_x} !== {10'd27, 10'd172, 1'b0}) begin errors++; $display("FAIL left_miss: got x=%0d y=%0d dir_x=%b expected 27 172 0", ball_loc_x, ball_loc_y, dir_x); end
    tick_n(5);
    checks++; if (ball_loc_x !== 10'd7) begin errors++; $display("FAIL tick224: got x=%0d expected 7", ball_loc_x); end
    tick_n(1);
    checks++; if ({ball_loc_x, ball_loc_y} !== {10'd4, 10'd196}) begin errors++; $display("FAIL left_goal_pos: got %0d,%0d expected 4,196", ball_loc_x, ball_loc_y); end
    checks++; if ({right_point, left_point, in_play} !== 3'b100) begin errors++; $display("FAIL left_goal_flags: got %b expected 100", {right_point, left_point, in_play}); end
    cycle();
    checks++; if (right_point !== 1'b0) begin errors++; $display("FAIL right_point_width: got %b expected 0", right_point); end
    tick_n(59);
    checks++; if ({ball_loc_x, ball_loc_y} !== {10'd4, 10'd196}) begin errors++; $display("FAIL left_hold_frozen: got %0d,%0d expected 4,196", ball_loc_x, ball_loc_y); end
    tick_n(1);
    checks++; if ({ball_loc_x, ball_loc_y, dir_x, dir_y, in_play} !== {10'd320, 10'd240, 1'b0, 1'b1, 1'b0}) begin errors++; $display("FAIL left_recentre: got x=%0d y=%0d dx=%b dy=%b ip=%b expected 320 240 0 1 0", ball_loc_x, ball_loc_y, dir_x, dir_y, in_play); end
  endtask

  task automatic test_right_miss_goal();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    right_paddle_loc = 10'd240;
    serve_pulse(1'b0);
    tick_n(73);
    checks++; if ({ball_loc_x, dir_x, left_point} !== {10'd612, 1'b1, 1'b0}) begin errors++; $display("FAIL right_miss: got x=%0d dir_x=%b lp=%b expected 612 1 0", ball_loc_x, dir_x, left_point); end
    tick_n(5);
    checks++; if (ball_loc_x !== 10'd632) begin errors++; $display("FAIL tick78: got x=%0d expected 632", ball_loc_x); end
    tick_n(1);
    checks++; if ({ball_loc_x, ball_loc_y} !== {10'd635, 10'd395}) begin errors++; $display("FAIL right_goal_pos: got %0d,%0d expected 635,395", ball_loc_x, ball_loc_y); end
    checks++; if ({left_point, right_point, in_play} !== 3'b100) begin errors++; $display("FAIL right_goal_flags: got %b expected 100", {left_point, right_point, in_play}); end
    cycle();
    checks++; if (left_point !== 1'b0) begin errors++; $display("FAIL left_point_width: got %b expected 0", left_point); end
    tick_n(59);
    checks++; if ({ball_loc_x, in_play} !== {10'd635, 1'b0}) begin errors++; $display("FAIL right_hold_frozen: got x=%0d ip=%b expected 635 0", ball_loc_x, in_play); end
    tick_n(1);
    checks++; if ({ball_loc_x, ball_loc_y, dir_x} !== {10'd320, 10'd240, 1'b1}) begin errors++; $display("FAIL right_recentre: got x=%0d y=%0d dx=%b expected 320 240 1", ball_loc_x, ball_loc_y, dir_x); end
    tick_n(1);
    checks++; if ({ball_loc_x, ball_loc_y, in_play} !== {10'd320, 10'd240, 1'b0}) begin errors++; $display("FAIL post_score_idle: got x=%0d y=%0d ip=%b expected 320 240 0", ball_loc_x, ball_loc_y, in_play); end
  endtask

  task automatic test_disable();
    serve_pulse(1'b0);
    tick_n(3);
    checks++; if ({ball_loc_x, in_play} !== {10'd332, 1'b1}) begin errors++; $display("FAIL pre_disable: got x=%0d ip=%b expected 332 1", ball_loc_x, in_play); end
    enable = 1'b0;
    cycle();
    checks++; if ({ball_loc_x, ball_loc_y, in_play, left_point, right_point} !== {10'd320, 10'd240, 3'b000}) begin errors++; $display("FAIL disable: got x=%0d y=%0d flags=%b expected 320 240 000", ball_loc_x, ball_loc_y, {in_play, left_point, right_point}); end
    tick_n(3);
    serve_pulse(1'b1);
    checks++; if ({ball_loc_x, ball_loc_y, in_play} !== {10'd320, 10'd240, 1'b0}) begin errors++; $display("FAIL disabled_ticks: got x=%0d y=%0d ip=%b expected 320 240 0", ball_loc_x, ball_loc_y, in_play); end
  endtask

  initial begin
    test_reset();
    test_serve_step();
    test_bottom_bounce();
    test_right_hit();
    test_left_goal();
    test_right_miss_goal();
    test_disable();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
